// File: rtl/rom_pkg.sv
// Shared constants and helpers for the ROM read arbiter and its response buffer.
package rom_pkg;

  localparam logic ROM_ENABLE  = 1'b0;
  localparam logic ROM_DISABLE = 1'b1;

  // Bits needed to index 'value' items; returns at least 1 so single-item widths stay legal.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rom_rsp_fifo.sv
// Two-entry response buffer; a push is accepted while full when a pop happens in the same cycle.
module rom_rsp_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop  = pop & (count_q != 2'd0);
    do_push = push & ((count_q != 2'd2) | do_pop);
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    pop_data = mem_q[rd_ptr_q];
    full     = (count_q == 2'd2);
    empty    = (count_q == 2'd0);
    count    = count_q;
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one single-port ROM among NUM_REQ readers, with a credit-limited response FIFO.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high; ready never waits on valid being stable for a cycle.
module rom_read_arbiter
  import rom_pkg::*;
#(
  parameter int ROM_DEPTH = 1024,
  parameter int NUM_DATA  = 1,
  parameter int BIT_WIDTH = 16,
  parameter int NUM_REQ   = 4,
  localparam int AW = clog2(ROM_DEPTH),
  localparam int DW = NUM_DATA * BIT_WIDTH,
  localparam int IW = clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rom_cen,
  output logic [AW-1:0]         rom_A,
  input  logic [DW-1:0]         rom_Q,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_data,
  output logic [IW-1:0]         rsp_id
);

  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             inflight_q, inflight_d;
  logic [IW-1:0]    inflight_id_q, inflight_id_d;
  logic [AW-1:0]    addr_q, addr_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_count;
  logic [IW+DW-1:0] fifo_head;
  logic             fifo_pop;

  logic [2:0]       occupancy;
  logic             issue_ok;
  logic             grant_any;
  logic [IW-1:0]    grant_idx;
  logic             grant_valid;
  logic [AW-1:0]    grant_addr;
  int unsigned      scan_idx;

  // Credits: buffered responses plus the read in flight, minus the one leaving this cycle.
  always_comb begin
    fifo_pop  = ~fifo_empty & rsp_ready;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
    issue_ok  = (occupancy < 3'd2);
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(unsigned'(rr_ptr_q)) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = IW'(scan_idx);
      end
    end
  end

  // rst_n gates the grant so nothing is offered to requesters while reset is held.
  always_comb begin
    grant_valid = rst_n & issue_ok & grant_any;
    grant_addr  = req_addr[grant_idx*AW +: AW];
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    inflight_d    = grant_valid;
    inflight_id_d = inflight_id_q;
    addr_d        = addr_q;
    if (grant_valid) begin
      rr_ptr_d      = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
      inflight_id_d = grant_idx;
      addr_d        = grant_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      addr_q        <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      addr_q        <= addr_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
    rom_cen   = grant_valid ? ROM_ENABLE : ROM_DISABLE;
    rom_A     = grant_valid ? grant_addr : addr_q;
    rsp_valid = ~fifo_empty;
    rsp_id    = fifo_head[IW+DW-1 -: IW];
    rsp_data  = fifo_head[DW-1:0];
  end

  // rom_Q belongs to the read registered as in flight on the previous edge.
  rom_rsp_fifo #(
    .WIDTH (IW + DW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data ({inflight_id_q, rom_Q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && fifo_full && !fifo_pop));

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: vector table for arbitration/latency/backpressure, hand sequences for reset and FIFO corners.
module tb_rom_read_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int NR = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     req_ready;
  logic              rom_cen;
  logic [AW-1:0]     rom_A;
  logic [DW-1:0]     rom_Q;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW-1:0]     rsp_data;
  logic [IW-1:0]     rsp_id;

  logic              f_push;
  logic [7:0]        f_wdata;
  logic              f_pop;
  logic [7:0]        f_rdata;
  logic              f_full;
  logic              f_empty;
  logic [1:0]        f_count;

  int checks;
  int errors;

  rom_read_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_cen   (rom_cen),
    .rom_A     (rom_A),
    .rom_Q     (rom_Q),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  rom_rsp_fifo #(.WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (f_push),
    .push_data (f_wdata),
    .pop       (f_pop),
    .pop_data  (f_rdata),
    .full      (f_full),
    .empty     (f_empty),
    .count     (f_count)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return 16'hA000 + DW'(a);
  endfunction

  // ROM model: data for the address enabled at an edge appears after that edge.
  always @(posedge clk) begin
    if (rom_cen == 1'b0) rom_Q <= rom_word(rom_A);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    f_push    = 1'b0;
    f_pop     = 1'b0;
    f_wdata   = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            rst_before;
    logic [NR-1:0] req_valid;
    logic          rsp_ready;
    logic [NR-1:0] exp_ready;
    logic          exp_cen;
    logic [AW-1:0] exp_a;
    logic          exp_rsp_valid;
    logic [IW-1:0] exp_id;
    logic [AW-1:0] exp_rsp_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rb, input logic [3:0] rv, input logic rr, input logic [3:0] er,
                     input logic cen, input int a, input logic sv, input int id, input int sa);
    vec_t v;
    v.rst_before    = rb;
    v.req_valid     = rv;
    v.rsp_ready     = rr;
    v.exp_ready     = er;
    v.exp_cen       = cen;
    v.exp_a         = AW'(a);
    v.exp_rsp_valid = sv;
    v.exp_id        = IW'(id);
    v.exp_rsp_addr  = AW'(sa);
    vecs.push_back(v);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    f_push    = 1'b0;
    f_pop     = 1'b0;
    f_wdata   = '0;
    // requester addresses: r0=10, r1=11, r2=5, r3=13
    req_addr  = {10'd13, 10'd5, 10'd11, 10'd10};

    // single requester 2, then requester 1 alone with rr_ptr=3, then rr_ptr=2 proven by 1+2 pending
    add(1, 4'b0100, 1, 4'b0100, 0,  5, 0, 0,  0);
    add(0, 4'b0000, 1, 4'b0000, 1,  5, 0, 0,  0);
    add(0, 4'b0000, 1, 4'b0000, 1,  5, 1, 2,  5);
    add(0, 4'b0010, 1, 4'b0010, 0, 11, 0, 0,  0);
    add(0, 4'b0000, 1, 4'b0000, 1, 11, 0, 0,  0);
    add(0, 4'b0110, 1, 4'b0100, 0,  5, 1, 1, 11);
    add(0, 4'b0000, 1, 4'b0000, 1,  5, 0, 0,  0);
    add(0, 4'b0000, 1, 4'b0000, 1,  5, 1, 2,  5);
    // all valid: 0,1,2,3,0 back to back, then drain, then backpressure and resume
    add(1, 4'b1111, 1, 4'b0001, 0, 10, 0, 0,  0);
    add(0, 4'b1111, 1, 4'b0010, 0, 11, 0, 0,  0);
    add(0, 4'b1111, 1, 4'b0100, 0,  5, 1, 0, 10);
    add(0, 4'b1111, 1, 4'b1000, 0, 13, 1, 1, 11);
    add(0, 4'b1111, 1, 4'b0001, 0, 10, 1, 2,  5);
    add(0, 4'b0000, 1, 4'b0000, 1, 10, 1, 3, 13);
    add(0, 4'b0000, 1, 4'b0000, 1, 10, 1, 0, 10);
    add(0, 4'b1111, 0, 4'b0010, 0, 11, 0, 0,  0);
    add(0, 4'b1111, 0, 4'b0100, 0,  5, 0, 0,  0);
    add(0, 4'b1111, 0, 4'b0000, 1,  5, 1, 1, 11);
    add(0, 4'b1111, 0, 4'b0000, 1,  5, 1, 1, 11);
    add(0, 4'b1111, 1, 4'b1000, 0, 13, 1, 1, 11);
    add(0, 4'b1111, 1, 4'b0001, 0, 10, 1, 2,  5);
    add(0, 4'b1111, 1, 4'b0010, 0, 11, 1, 3, 13);
    add(0, 4'b0000, 1, 4'b0000, 1, 11, 1, 0, 10);
    add(0, 4'b0000, 1, 4'b0000, 1, 11, 1, 1, 11);
    add(0, 4'b0000, 1, 4'b0000, 1, 11, 0, 0,  0);

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) begin
        do_reset();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rom_cen", 32'(rom_cen), 32'd1);
        check("reset_rom_A", 32'(rom_A), 32'd0);
      end
      @(posedge clk);
      #1;
      req_valid = vecs[i].req_valid;
      rsp_ready = vecs[i].rsp_ready;
      @(negedge clk);
      check($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_rom_cen", i), 32'(rom_cen), 32'(vecs[i].exp_cen));
      check($sformatf("v%0d_rom_A", i), 32'(rom_A), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rsp_valid));
      if (vecs[i].exp_rsp_valid) begin
        check($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(vecs[i].exp_id));
        check($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(rom_word(vecs[i].exp_rsp_addr)));
      end
    end

    // reset asserted with a read in flight: outputs drop without an edge, stale data never shows
    do_reset();
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    @(negedge clk);
    check("mid_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_rom_cen", 32'(rom_cen), 32'd1);
    check("mid_rst_rom_A", 32'(rom_A), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b1010;
    @(negedge clk);
    check("post_rst_grant", 32'(req_ready), 32'b0010);
    check("post_rst_addr", 32'(rom_A), 32'd11);
    @(posedge clk);
    #1;
    req_valid = '0;

    // response buffer: full with simultaneous push and pop keeps count and order
    do_reset();
    @(posedge clk);
    #1;
    f_push  = 1'b1;
    f_wdata = 8'h11;
    @(posedge clk);
    #1;
    f_wdata = 8'h22;
    @(posedge clk);
    #1;
    f_push = 1'b0;
    @(negedge clk);
    check("fifo_count_full", 32'(f_count), 32'd2);
    check("fifo_full_flag", 32'(f_full), 32'd1);
    check("fifo_head_a", 32'(f_rdata), 32'h11);
    @(posedge clk);
    #1;
    f_push  = 1'b1;
    f_wdata = 8'h33;
    f_pop   = 1'b1;
    @(posedge clk);
    #1;
    f_push = 1'b0;
    f_pop  = 1'b0;
    @(negedge clk);
    check("fifo_count_pushpop", 32'(f_count), 32'd2);
    check("fifo_head_b", 32'(f_rdata), 32'h22);
    @(posedge clk);
    #1;
    f_pop = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    f_pop = 1'b0;
    @(negedge clk);
    check("fifo_head_c", 32'(f_rdata), 32'h33);
    check("fifo_count_one", 32'(f_count), 32'd1);
    @(posedge clk);
    #1;
    f_pop = 1'b1;
    @(posedge clk);
    #1;
    f_pop = 1'b0;
    @(negedge clk);
    check("fifo_empty_flag", 32'(f_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 SHALL have parameter ROM_DEPTH, default 1024, ROM word count; AW = clog2(ROM_DEPTH).
REQ-002 SHALL have parameter NUM_DATA, default 1, data items per ROM word.
REQ-003 SHALL have parameter BIT_WIDTH, default 16, bits per data item; DW = NUM_DATA*BIT_WIDTH.
REQ-004 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8); IW = clog2(NUM_REQ).
REQ-005 SHALL have port clk, input, 1, the single system clock, rising-edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, NUM_REQ, one read request per requester.
REQ-008 SHALL have port req_addr, input, NUM_REQ*AW, requester i address in slice [i*AW+:AW].
REQ-009 SHALL have port req_ready, output, NUM_REQ, grant; the handshake completes when req_valid[i] and req_ready[i] are both high.
REQ-010 SHALL have port rom_cen, output, 1, ROM chip enable, active low.
REQ-011 SHALL have port rom_A, output, AW, ROM address.
REQ-012 SHALL have port rom_Q, input, DW, ROM data, valid the cycle after the enabled edge.
REQ-013 SHALL have port rsp_valid, output, 1, response available.
REQ-014 SHALL have port rsp_ready, input, 1, response consumer ready.
REQ-015 SHALL have port rsp_data, output, DW, returned ROM word.
REQ-016 SHALL have port rsp_id, output, IW, index of the requester that issued the read.

Function
REQ-017 SHALL compute issue_ok = (fifo_count + inflight - (rsp_valid & rsp_ready)) < 2.
REQ-018 SHALL, when issue_ok, assert exactly one req_ready bit: the first valid requester at or after rr_ptr, searching upward with wrap.
REQ-019 SHALL drive req_ready to all zeros when issue_ok is low or no req_valid bit is set.
REQ-020 SHALL drive rom_cen low and rom_A = req_addr of the granted requester combinationally in the grant cycle; otherwise rom_cen is high and rom_A holds its last issued value.
REQ-021 SHALL, on each grant to requester g, update rr_ptr to (g+1) mod NUM_REQ at the clock edge; rr_ptr holds when there is no grant.
REQ-022 SHALL register inflight=1 and inflight_id=g on the grant edge, and clear inflight the next edge if there is no new grant.
REQ-023 SHALL, when inflight=1, write {inflight_id, rom_Q} into a 2-entry response FIFO at the next edge.
REQ-024 SHALL give a response latency of 2 cycles: a grant at edge k makes rsp_valid high after edge k+1.
REQ-025 SHALL sustain one grant per cycle when rsp_ready is held high.
REQ-026 SHALL return responses in grant order; rsp_data and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
REQ-027 SHALL support a FIFO push and pop in the same cycle, including when the FIFO is full; fifo_count is then unchanged.
REQ-028 SHALL never overflow the FIFO: the credit rule in REQ-017 guarantees fifo_count+inflight <= 2.
REQ-029 SHALL allow a requester to hold req_valid across cycles; a request that is not granted is not consumed.

Reset
REQ-030 SHALL, while rst_n is low, immediately set rr_ptr=0, inflight=0, inflight_id=0, fifo_count=0, rsp_valid=0, rom_cen=1, rom_A=0 and req_ready=0.
REQ-031 SHALL discard any in-flight read and any buffered responses when reset is asserted mid-operation; the first grant after release goes to the lowest-index valid requester.

Structure
REQ-032 SHALL place ROM_ENABLE=1'b0, ROM_DISABLE=1'b1 and the clog2 function in the shared package rom_pkg.
REQ-033 SHALL implement the response buffer as a sub-module rom_rsp_fifo, 2 entries, width IW+DW, with push, pop, full, empty and count signals.

Verification
REQ-034 SHALL cover this scenario: single requester 2 with addr 5 and rsp_ready=1 -> rom_cen low for 1 cycle with rom_A=5; rsp_valid 2 cycles later with rsp_id=2 and rsp_data=rom_Q.
REQ-035 SHALL cover this scenario: all 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0; one grant per cycle; rsp_id sequence matches.
REQ-036 SHALL cover this scenario: rsp_ready=0 with requests pending -> exactly 2 grants, then req_ready=0; when rsp_ready returns to 1, grants resume at 1 per cycle.
REQ-037 SHALL cover this scenario: full FIFO with simultaneous push and pop -> count stays 2 and no response is lost.
REQ-038 SHALL cover this scenario: rst_n driven low during an in-flight read -> all outputs reach reset values without a clock edge; the stale response never appears.
REQ-039 SHALL cover this scenario: requester 1 only, with rr_ptr=3 -> grant goes to requester 1 and rr_ptr then equals 2.
